// File: rtl/nn_avl_mem_responder_if.sv
// Avalon-style word memory bus between a requester (master) and responder (slave).
// Grouping the bus here keeps the responder port list and the bench hookup short.
interface nn_avl_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              avl_ready;
  logic [ADDR_W-1:0] avl_addr;
  logic              avl_read_req;
  logic              avl_write_req;
  logic [DATA_W-1:0] avl_wdata;
  logic [DATA_W-1:0] avl_rdata;
  logic              avl_rdata_valid;

  modport master (
    input  avl_ready, avl_rdata, avl_rdata_valid,
    output avl_addr, avl_read_req, avl_write_req, avl_wdata
  );

  modport slave (
    output avl_ready, avl_rdata, avl_rdata_valid,
    input  avl_addr, avl_read_req, avl_write_req, avl_wdata
  );
endinterface

// File: rtl/nn_avl_mem_responder.sv
// Memory responder model: calibration delay, fixed read latency,
// outstanding-read limit, optional periodic ready stalls, sticky error flag.
module nn_avl_mem_responder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 4,
  parameter int MAX_OUT      = 4,
  parameter int INIT_CYCLES  = 30,
  parameter int STALL_PERIOD = 0
) (
  input  logic clk,
  input  logic reset,
  nn_avl_mem_responder_if.slave avl,
  output logic err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = (DATA_W > 32) ? DATA_W : 32;
  localparam int SP    = (STALL_PERIOD > 0) ? STALL_PERIOD : 1;
  localparam int SW    = $clog2(SP + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [7:0]        init_cnt;
  logic [SW-1:0]     stall_cnt;
  logic [3:0]        outstanding;
  logic [DEPTH-1:0]  written;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LATENCY-1:0] pv;
  logic [DATA_W-1:0] pd [RD_LATENCY];

  logic              stall_slot;
  logic              ready;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_both;
  logic              ret;
  logic [PW-1:0]     pat_w;
  logic [DATA_W-1:0] rd_word;

  assign stall_slot = (STALL_PERIOD > 0) && (stall_cnt == SW'(SP - 1));
  assign ready      = (state == RUN) && (outstanding < 4'(MAX_OUT)) && !stall_slot;
  assign acc_rd     = ready && avl.avl_read_req;
  assign acc_both   = acc_rd && avl.avl_write_req;
  assign acc_wr     = ready && avl.avl_write_req && !avl.avl_read_req;
  assign ret        = pv[RD_LATENCY-1];

  // Never-written words read back as an address-tagged pattern
  assign pat_w   = PW'(32'hA5A5_0000) ^ PW'(avl.avl_addr);
  assign rd_word = written[avl.avl_addr] ? mem[avl.avl_addr]
                                         : pat_w[DATA_W-1:0];

  assign avl.avl_ready       = ready;
  assign avl.avl_rdata_valid = ret;
  assign avl.avl_rdata       = pd[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      stall_cnt   <= '0;
      outstanding <= '0;
      written     <= '0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (init_cnt == 8'(INIT_CYCLES - 1)) state <= RUN;
          else init_cnt <= init_cnt + 8'd1;
        end
        RUN: begin
          if (stall_cnt == SW'(SP - 1)) stall_cnt <= '0;
          else stall_cnt <= stall_cnt + SW'(1);
        end
        default: state <= INIT;
      endcase
      unique case ({acc_rd, ret})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (acc_wr) written[avl.avl_addr] <= 1'b1;
      if (acc_both) err <= 1'b1;
    end
  end

  // Storage has no reset; the written bits decide what a read sees
  always_ff @(posedge clk) begin
    if (acc_wr) mem[avl.avl_addr] <= avl.avl_wdata;
  end

  // Data only advances with a valid token so the output holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= acc_rd;
      if (acc_rd) pd[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end
endmodule

// File: tb/tb_nn_avl_mem_responder.sv
// Scoreboard bench: reads push expected words at accept time,
// monitors pop and compare data and latency on every valid strobe.
module tb_nn_avl_mem_responder;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic err0, err1;

  always #5 clk = ~clk;

  nn_avl_mem_responder_if m0 ();
  nn_avl_mem_responder_if m1 ();

  nn_avl_mem_responder u0 (
    .clk   (clk),
    .reset (rst0),
    .avl   (m0),
    .err   (err0)
  );

  nn_avl_mem_responder #(.MAX_OUT(15), .STALL_PERIOD(5)) u1 (
    .clk   (clk),
    .reset (rst1),
    .avl   (m1),
    .err   (err1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [31:0] exp0, exp1;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int t0[$];
  int t1[$];
  int acc0[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m0.avl_rdata_valid) begin
      if (q0.size() == 0) chk("valid0_unexpected", 32'(m0.avl_rdata_valid), 0);
      else begin
        chk("rdata0", m0.avl_rdata, q0.pop_front());
        chk("latency0", 32'(cyc), 32'(t0.pop_front()));
      end
    end
    if (!rst0 && m0.avl_ready && m0.avl_read_req) begin
      q0.push_back(exp0);
      t0.push_back(cyc + RL);
      acc0.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (m1.avl_rdata_valid) begin
      if (q1.size() == 0) chk("valid1_unexpected", 32'(m1.avl_rdata_valid), 0);
      else begin
        chk("rdata1", m1.avl_rdata, q1.pop_front());
        chk("latency1", 32'(cyc), 32'(t1.pop_front()));
      end
    end
    if (!rst1 && m1.avl_ready && m1.avl_read_req) begin
      q1.push_back(exp1);
      t1.push_back(cyc + RL);
    end
  end

  task automatic wait_ready0(output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!m0.avl_ready && k < 40);
  endtask

  task automatic req0(input logic [7:0] a, input logic rd, input logic wr,
                      input logic [31:0] d, input logic [31:0] e);
    int n;
    m0.avl_addr = a;
    m0.avl_read_req = rd;
    m0.avl_write_req = wr;
    m0.avl_wdata = d;
    exp0 = e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0.avl_ready && n < 50);
    if (!m0.avl_ready) chk("accept_timeout", 32'(m0.avl_ready), 1);
    @(posedge clk); #1;
    m0.avl_read_req = 1'b0;
    m0.avl_write_req = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (q0.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain0", 32'(q0.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while (q1.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain1", 32'(q1.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, lows, last;
    rst0 = 1'b1;
    rst1 = 1'b1;
    m0.avl_addr = '0; m0.avl_read_req = 1'b0;
    m0.avl_write_req = 1'b0; m0.avl_wdata = '0;
    m1.avl_addr = '0; m1.avl_read_req = 1'b0;
    m1.avl_write_req = 1'b0; m1.avl_wdata = '0;
    exp0 = '0;
    exp1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;

    chk("reset_ready", 32'(m0.avl_ready), 0);
    chk("reset_valid", 32'(m0.avl_rdata_valid), 0);
    chk("reset_rdata", m0.avl_rdata, 0);
    chk("reset_err", 32'(err0), 0);

    wait_ready0(k);
    chk("init_len", 32'(k), 30);

    // write, read back, untouched neighbour, read-before-write ordering
    req0(8'h12, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
    req0(8'h12, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    req0(8'h13, 1'b1, 1'b0, 32'h0, 32'hA5A5_0013);
    req0(8'h12, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    req0(8'h12, 1'b0, 1'b1, 32'h1111_2222, 32'h0);
    req0(8'h12, 1'b1, 1'b0, 32'h0, 32'h1111_2222);
    drain0();

    // six held reads against the outstanding limit
    acc0.delete();
    for (int i = 0; i < 6; i++)
      req0(8'h40 + 8'(i), 1'b1, 1'b0, 32'h0, 32'hA5A5_0040 + 32'(i));
    chk("burst_first4", 32'(acc0[3] - acc0[0]), 3);
    chk("burst_gap", 32'(acc0[4] - acc0[3]), 2);
    chk("burst_tail", 32'(acc0[5] - acc0[4]), 1);
    drain0();

    // simultaneous read and write
    req0(8'h20, 1'b1, 1'b1, 32'h1, 32'hA5A5_0020);
    chk("err_set", 32'(err0), 1);
    req0(8'h20, 1'b1, 1'b0, 32'h0, 32'hA5A5_0020);
    drain0();
    chk("err_sticky", 32'(err0), 1);

    // reset with three reads in flight
    for (int i = 0; i < 3; i++)
      req0(8'h12, 1'b1, 1'b0, 32'h0, 32'h1111_2222);
    rst0 = 1'b1;
    q0.delete();
    t0.delete();
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    chk("rst2_ready", 32'(m0.avl_ready), 0);
    chk("rst2_err", 32'(err0), 0);
    chk("rst2_valid", 32'(m0.avl_rdata_valid), 0);
    wait_ready0(k);
    chk("init_len2", 32'(k), 30);
    acc0.delete();
    for (int i = 0; i < 4; i++)
      req0(8'h12, 1'b1, 1'b0, 32'h0, 32'hA5A5_0012);
    chk("rst2_outstanding", 32'(acc0[3] - acc0[0]), 3);
    drain0();

    // periodic stall on the second instance with reads held high
    m1.avl_addr = 8'h30;
    exp1 = 32'hA5A5_0030;
    m1.avl_read_req = 1'b1;
    lows = 0;
    last = -1;
    repeat (40) begin
      @(negedge clk);
      if (!m1.avl_ready) begin
        lows++;
        if (last >= 0) chk("stall_gap", 32'(cyc - last), 5);
        last = cyc;
      end
    end
    chk("stall_count", 32'(lows), 8);
    @(posedge clk); #1;
    m1.avl_read_req = 1'b0;
    drain1();
    chk("stall_err", 32'(err1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nn_avl_mem_responder.md
NN_AVL_MEM_RESPONDER -- requirements
Module: nn_avl_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter RD_LATENCY, default 4, accept-to-data cycles, legal range 1..15.
REQ-004 SHALL have parameter MAX_OUT, default 4, maximum outstanding reads, legal range 1..15.
REQ-005 SHALL have parameter INIT_CYCLES, default 30, post-reset calibration cycles with ready low, legal range 1..255.
REQ-006 SHALL have parameter STALL_PERIOD, default 0, period of one-cycle injected ready stall; 0 disables stalls.
REQ-007 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port avl_ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL have port avl_addr  input  ADDR_W  word address.
REQ-011 SHALL have port avl_read_req  input  1  read request.
REQ-012 SHALL have port avl_write_req  input  1  write request.
REQ-013 SHALL have port avl_wdata  input  DATA_W  write data.
REQ-014 SHALL have port avl_rdata  output  DATA_W  read data, meaningful only while avl_rdata_valid is high.
REQ-015 SHALL have port avl_rdata_valid  output  1  one-cycle strobe per returned read word.
REQ-016 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL implement two states: INIT (calibration) and RUN.
REQ-018 SHALL enter INIT on reset and, in INIT, count INIT_CYCLES clocks, then move to RUN; RUN is held until reset.
REQ-019 SHALL drive avl_ready = (state==RUN) && (outstanding < MAX_OUT) && !stall_slot, decoded combinationally from registered state.
REQ-020 SHALL, when STALL_PERIOD>0, run a free-running RUN-state cycle counter wrapping at STALL_PERIOD-1; stall_slot is high on the cycle the counter equals STALL_PERIOD-1.
REQ-021 SHALL accept a request only in a cycle with avl_ready high; requests while avl_ready is low are ignored, with no state change and no error.
REQ-022 SHALL, on accepted write, store avl_wdata at avl_addr at that clock edge and set that word's written bit.
REQ-023 SHALL, on accepted read at cycle N, sample the memory at cycle N and present the word with avl_rdata_valid high exactly at cycle N+RD_LATENCY.
REQ-024 SHALL return, for a word whose written bit is clear, the pattern {DATA_W-ADDR_W zeros, addr} XOR 32'hA5A5_0000, truncated or zero-extended to DATA_W.
REQ-025 SHALL give write-then-read to the same address in later cycles the new data; read-then-write before the response SHALL return the old data.
REQ-026 SHALL return read data strictly in acceptance order; back-to-back accepted reads SHALL give back-to-back valid strobes.
REQ-027 SHALL increment outstanding on read accept and decrement it on avl_rdata_valid; both in one cycle leave it unchanged; it never exceeds MAX_OUT.
REQ-028 SHALL treat avl_read_req and avl_write_req both high in an accepted cycle as an error: serve the read, drop the write, set err.
REQ-029 SHALL hold avl_rdata at its last value when avl_rdata_valid is low.

Reset
REQ-030 SHALL, on reset high at a clock edge, set state=INIT, INIT counter=0, stall counter=0, outstanding=0, clear all read-pipeline valid bits, clear all written bits, set err=0.
REQ-031 SHALL drive avl_ready=0, avl_rdata_valid=0, avl_rdata=0, err=0 in the cycle after reset and throughout INIT.
REQ-032 SHALL discard in-flight reads when reset is asserted mid-operation; no avl_rdata_valid SHALL appear for pre-reset requests.
REQ-033 SHALL leave memory contents undefined across reset; the cleared written bits make reads return the REQ-024 pattern.

Verification
REQ-034 SHALL be verified by: reset 3 cycles, then idle -> avl_ready rises exactly INIT_CYCLES (30) cycles after reset falls.
REQ-035 SHALL be verified by: write 32'hDEADBEEF @0x12, then read @0x12 -> avl_rdata=32'hDEADBEEF with valid 4 cycles after the read accept; read @0x13 -> 32'hA5A5_0013.
REQ-036 SHALL be verified by: 6 consecutive reads held with the MAX_OUT=4 default -> 4 accepted, ready low until the first valid returns, then the remaining reads accepted; 6 in-order strobes.
REQ-037 SHALL be verified by: STALL_PERIOD=5 with continuous reads -> ready low exactly one cycle in every 5 RUN cycles, and no accepts in stalled cycles.
REQ-038 SHALL be verified by: read and write both high @0x20 with wdata 1 -> err=1 and stays 1, read served, a later read @0x20 returns 32'hA5A5_0020.
REQ-039 SHALL be verified by: reset asserted with 3 reads outstanding -> no rdata_valid afterward, outstanding=0, and INIT re-entered.
